// File: rtl/uart_ctrl_pkg.sv
// Shared constants, state encoding and a width helper for the UART transmit arbiter.
// Pure declarations: no logic, no latency, no backpressure.
package uart_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int LCR_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_e;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter bundle seen by the arbiter; master = requesters + transmitter, slave = arbiter.
// Wires only: no latency, no backpressure.
interface uart_tx_arbiter_if
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int OWN_W = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [LCR_W*NUM_REQ-1:0]  req_lcr;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         tx_data;
    logic [LCR_W-1:0]          tx_lcr;
    logic                      tx_start;
    logic                      tx_done;
    logic                      busy;
    logic [OWN_W-1:0]          owner;
    logic                      err_timeout;

    modport master (
        output req, req_data, req_lcr, tx_done,
        input  grant, tx_data, tx_lcr, tx_start, busy, owner, err_timeout
    );

    modport slave (
        input  req, req_data, req_lcr, tx_done,
        output grant, tx_data, tx_lcr, tx_start, busy, owner, err_timeout
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: priority starts one past last_owner and walks upward with wrap.
// Zero latency; no backpressure (pure function of req and last_owner).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   index,
    output logic               any_req
);

    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        index  = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_owner) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                index       = IDX_W'(idx);
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters: grant + tx_start one cycle after req, held until tx_done.
// Optional watchdog abort of a stuck frame when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);

    localparam int OWN_W = idx_w(NUM_REQ);

    arb_state_e          state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic                tx_start_q;
    logic                busy_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic [LCR_W-1:0]    tx_lcr_q;
    logic [OWN_W-1:0]    owner_q;
    logic [OWN_W-1:0]    last_owner_q;

    logic [NUM_REQ-1:0]  win_onehot;
    logic [OWN_W-1:0]    win_idx;
    logic                any_req;
    logic [DATA_W-1:0]   tx_data_d;
    logic [LCR_W-1:0]    tx_lcr_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWN_W)
    ) u_rr (
        .req        (bus.req),
        .last_owner (last_owner_q),
        .winner     (win_onehot),
        .index      (win_idx),
        .any_req    (any_req)
    );

    assign tx_data_d = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
    assign tx_lcr_d  = bus.req_lcr[int'(win_idx)*LCR_W +: LCR_W];

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = idx_w(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             err_timeout_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            tx_data_q     <= '0;
            tx_lcr_q      <= '0;
            owner_q       <= '0;
            last_owner_q  <= OWN_W'(NUM_REQ - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            grant_q       <= '0;
            tx_start_q    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
            unique case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q    <= ST_START;
                        grant_q    <= win_onehot;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        tx_data_q  <= tx_data_d;
                        tx_lcr_q   <= tx_lcr_d;
                        owner_q    <= win_idx;
                    end
                end
                ST_START: begin
                    // tx_done seen here belongs to a previous frame and is dropped.
                    state_q <= ST_WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                ST_WAIT_DONE: begin
                    if (bus.tx_done) begin
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        last_owner_q <= owner_q;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        last_owner_q  <= owner_q;
                        err_timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_lcr   = tx_lcr_q;
    assign bus.owner    = owner_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    assign bus.err_timeout = err_timeout_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of transactions checked through a start-strobe scoreboard,
// plus hand sequences for fairness, reset abort and (when enabled) the watchdog.
module tb_uart_tx_arbiter;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [19:0] lcr;
        int          dly;
        bit          stale;
        logic [3:0]  e_grant;
        logic [7:0]  e_data;
        logic [4:0]  e_lcr;
        logic [1:0]  e_owner;
    } vec_t;

    typedef struct {
        logic [3:0] grant;
        logic [7:0] data;
        logic [4:0] lcr;
        logic [1:0] owner;
    } exp_t;

    localparam logic [19:0] LCR_WORD = {5'h15, 5'h0A, 5'h01, 5'h1F};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    vec_t vecs[11];
    logic [4:0] lcr_of[4];

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every tx_start must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_start) begin
                if (exp_q.size() == 0) begin
                    check("start_without_request", 32'(bus.tx_start), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_grant", 32'(bus.grant), 32'(e.grant));
                    check("sb_tx_data", 32'(bus.tx_data), 32'(e.data));
                    check("sb_tx_lcr", 32'(bus.tx_lcr), 32'(e.lcr));
                    check("sb_owner", 32'(bus.owner), 32'(e.owner));
                end
            end else begin
                check("grant_without_start", 32'(bus.grant), 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
        check({tag, "_tx_lcr"}, 32'(bus.tx_lcr), 32'd0);
        check({tag, "_owner"}, 32'(bus.owner), 32'd0);
        check({tag, "_err_timeout"}, 32'(bus.err_timeout), 32'd0);
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_lcr  = '0;
        bus.tx_done  = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where busy has dropped.
    task automatic run_txn(input vec_t v, input bit hold);
        exp_t e;
        bus.req      = v.req;
        bus.req_data = v.data;
        bus.req_lcr  = v.lcr;
        e.grant = v.e_grant;
        e.data  = v.e_data;
        e.lcr   = v.e_lcr;
        e.owner = v.e_owner;
        exp_q.push_back(e);
        @(negedge clk);
        check("start_latency", 32'(bus.tx_start), 32'd1);
        check("busy_at_start", 32'(bus.busy), 32'd1);
        if (!hold) bus.req = '0;
        if (v.stale) bus.tx_done = 1'b1;
        for (int c = 1; c <= v.dly; c++) begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            if (c == 1) check("start_one_cycle", 32'(bus.tx_start), 32'd0);
            check("wait_busy", 32'(bus.busy), 32'd1);
            check("no_timeout", 32'(bus.err_timeout), 32'd0);
        end
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        check("busy_drop", 32'(bus.busy), 32'd0);
        check("data_hold", 32'(bus.tx_data), 32'(v.e_data));
        check("lcr_hold", 32'(bus.tx_lcr), 32'(v.e_lcr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        exp_t e;
        lcr_of = '{5'h1F, 5'h01, 5'h0A, 5'h15};
        //         req      data                                 lcr       dly stale grant    data   lcr    own
        vecs[0]  = '{4'b0010, 32'h3322AA11,                       LCR_WORD, 3, 1'b0, 4'b0010, 8'hAA, 5'h01, 2'd1};
        vecs[1]  = '{4'b1111, {8'h13, 8'h12, 8'h11, 8'h10},      LCR_WORD, 1, 1'b0, 4'b0100, 8'h12, 5'h0A, 2'd2};
        vecs[2]  = '{4'b1111, {8'h23, 8'h22, 8'h21, 8'h20},      LCR_WORD, 2, 1'b1, 4'b1000, 8'h23, 5'h15, 2'd3};
        vecs[3]  = '{4'b1001, {8'h33, 8'h32, 8'h31, 8'h30},      LCR_WORD, 3, 1'b0, 4'b0001, 8'h30, 5'h1F, 2'd0};
        vecs[4]  = '{4'b1001, {8'h43, 8'h42, 8'h41, 8'h40},      LCR_WORD, 5, 1'b1, 4'b1000, 8'h43, 5'h15, 2'd3};
        vecs[5]  = '{4'b0110, {8'h53, 8'h52, 8'h51, 8'h50},      LCR_WORD, 2, 1'b0, 4'b0010, 8'h51, 5'h01, 2'd1};
        vecs[6]  = '{4'b0001, {8'h63, 8'h62, 8'h61, 8'h60},      LCR_WORD, 1, 1'b0, 4'b0001, 8'h60, 5'h1F, 2'd0};
        vecs[7]  = '{4'b1010, {8'h73, 8'h72, 8'h71, 8'h70},      LCR_WORD, 2, 1'b0, 4'b0010, 8'h71, 5'h01, 2'd1};
        vecs[8]  = '{4'b1010, {8'h83, 8'h82, 8'h81, 8'h80},      LCR_WORD, 3, 1'b0, 4'b1000, 8'h83, 5'h15, 2'd3};
        vecs[9]  = '{4'b0100, {8'h93, 8'h92, 8'h91, 8'h90},      LCR_WORD, 1, 1'b0, 4'b0100, 8'h92, 5'h0A, 2'd2};
        vecs[10] = '{4'b1111, {8'hA3, 8'hA2, 8'hA1, 8'hA0},      LCR_WORD, 1, 1'b0, 4'b1000, 8'hA3, 5'h15, 2'd3};

        apply_reset();
        for (int i = 0; i < 11; i++) run_txn(vecs[i], 1'b0);

        // Fairness: all four held from reset, expect owners 0,1,2,3,0.
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            v.req     = 4'b1111;
            v.data    = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
            v.lcr     = LCR_WORD;
            v.dly     = 3;
            v.stale   = 1'b0;
            v.e_owner = 2'(k % 4);
            v.e_grant = 4'b0001 << (k % 4);
            v.e_data  = 8'hB0 + 8'(k % 4);
            v.e_lcr   = lcr_of[k % 4];
            run_txn(v, 1'b1);
        end
        bus.req = '0;
        repeat (2) @(negedge clk);

        // Reset while waiting for tx_done: outputs clear at once, no re-grant.
        bus.req      = 4'b0001;
        bus.req_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        bus.req_lcr  = LCR_WORD;
        e = '{4'b0001, 8'hC0, 5'h1F, 2'd0};
        exp_q.push_back(e);
        @(negedge clk);
        check("abort_start", 32'(bus.tx_start), 32'd1);
        bus.req = '0;
        @(negedge clk);
        check("abort_wait_busy", 32'(bus.busy), 32'd1);
        #1 rst = 1'b1;
        #1 check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_no_reissue", 32'(bus.busy), 32'd0);
        end
        v = '{4'b0100, {8'hD3, 8'hD2, 8'hD1, 8'hD0}, LCR_WORD, 2, 1'b0, 4'b0100, 8'hD2, 5'h0A, 2'd2};
        run_txn(v, 1'b0);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Watchdog: tx_done never comes; abort after 16 WAIT_DONE cycles, then requester 1 follows.
        apply_reset();
        bus.req      = 4'b0011;
        bus.req_data = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        bus.req_lcr  = LCR_WORD;
        e = '{4'b0001, 8'hE0, 5'h1F, 2'd0};
        exp_q.push_back(e);
        @(negedge clk);
        check("tmo_start", 32'(bus.tx_start), 32'd1);
        e = '{4'b0010, 8'hE1, 5'h01, 2'd1};
        exp_q.push_back(e);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check("tmo_wait_busy", 32'(bus.busy), 32'd1);
            check("tmo_no_err_yet", 32'(bus.err_timeout), 32'd0);
        end
        @(negedge clk);
        check("tmo_err_pulse", 32'(bus.err_timeout), 32'd1);
        check("tmo_busy_drop", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.req = '0;
        check("tmo_next_start", 32'(bus.tx_start), 32'd1);
        check("tmo_err_one_cycle", 32'(bus.err_timeout), 32'd0);
        @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        check("tmo_final_idle", 32'(bus.busy), 32'd0);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
